// File: rtl/pkg_dtypes.sv
// Shared front-end datatypes.
//   LOG2_NUM_EXEC_UNITS : width of an execution-unit index
//   type_iqueue_entry   : one renamed instruction as written into an EU issue queue
package pkg_dtypes;
  localparam int LOG2_NUM_EXEC_UNITS = 2;

  typedef struct packed {
    logic [6:0] opcode;
    logic [5:0] prd;
    logic [7:0] rob_idx;
  } type_iqueue_entry;
endpackage

// File: rtl/fe_dispatch_ctrl_if.sv
// Rename -> dispatch -> EU queue handshake bundle.
//   master : the dispatch controller (takes batches, drives the dispatch bus)
//   slave  : the environment (rename + EU queues)
// Signals: batch_instr_i/batch_lane_valid_i/batch_valid_i/batch_ready_o (rename side),
//          flush_i, dispatched_instr_o/_valid_o/_alloc_euidx_o, eu_is_full_i (EU side),
//          retry_count_o (status).
interface fe_dispatch_ctrl_if #(
  parameter int N  = 4,
  parameter int LW = pkg_dtypes::LOG2_NUM_EXEC_UNITS
);
  localparam int NUM_EU = 2**LW;

  pkg_dtypes::type_iqueue_entry [N-1:0] batch_instr_i;
  logic [N-1:0]                         batch_lane_valid_i;
  logic                                 batch_valid_i;
  logic                                 batch_ready_o;
  logic                                 flush_i;
  pkg_dtypes::type_iqueue_entry [N-1:0] dispatched_instr_o;
  logic [N-1:0]                         dispatched_instr_valid_o;
  logic [N-1:0][LW-1:0]                 dispatched_instr_alloc_euidx_o;
  logic [NUM_EU-1:0]                    eu_is_full_i;
  logic [7:0]                           retry_count_o;

  modport master (
    input  batch_instr_i, batch_lane_valid_i, batch_valid_i, flush_i, eu_is_full_i,
    output batch_ready_o, dispatched_instr_o, dispatched_instr_valid_o,
           dispatched_instr_alloc_euidx_o, retry_count_o
  );

  modport slave (
    output batch_instr_i, batch_lane_valid_i, batch_valid_i, flush_i, eu_is_full_i,
    input  batch_ready_o, dispatched_instr_o, dispatched_instr_valid_o,
           dispatched_instr_alloc_euidx_o, retry_count_o
  );
endinterface

// File: rtl/fe_dispatch_euidx_alloc.sv
// Round-robin EU allocation for one batch (combinational).
//   lane_valid  : per-lane valid
//   rr_ptr      : EU index given to the lowest valid lane
//   euidx       : per-lane EU index (0 on invalid lanes)
//   rr_ptr_next : rr_ptr advanced by the number of valid lanes
module fe_dispatch_euidx_alloc #(
  parameter int N  = 4,
  parameter int LW = 2
) (
  input  logic [N-1:0]         lane_valid,
  input  logic [LW-1:0]        rr_ptr,
  output logic [N-1:0][LW-1:0] euidx,
  output logic [LW-1:0]        rr_ptr_next
);
  // prefix[k] = rr_ptr + (valid lanes below k); LW-bit truncation gives the
  // modulo-NUM_EU wrap for free.
  logic [N:0][LW-1:0] prefix;

  assign prefix[0] = rr_ptr;

  for (genvar k = 0; k < N; k++) begin : g_lane
    assign prefix[k+1] = prefix[k] + LW'(lane_valid[k]);
    assign euidx[k]    = lane_valid[k] ? prefix[k] : '0;
  end

  assign rr_ptr_next = prefix[N];
endmodule

// File: rtl/fe_dispatch_ctrl.sv
// Front-end dispatch controller: holds one renamed batch on the dispatch bus
// until no EU requests a retry, allocating EUs round-robin at capture.
//   clk, reset_n : clock, synchronous active-low reset
//   bus          : fe_dispatch_ctrl_if.master (batch in, dispatch bus out,
//                  per-EU retry in, saturating retry counter out)
module fe_dispatch_ctrl #(
  parameter int NUM_PARALLEL_INSTR_DISPATCHES = 4,
  parameter int LOG2_NUM_EXEC_UNITS           = pkg_dtypes::LOG2_NUM_EXEC_UNITS
) (
  input  logic               clk,
  input  logic               reset_n,
  fe_dispatch_ctrl_if.master bus
);
  localparam int N  = NUM_PARALLEL_INSTR_DISPATCHES;
  localparam int LW = LOG2_NUM_EXEC_UNITS;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                               state_q, state_d;
  logic [LW-1:0]                        rr_ptr, rr_ptr_next;
  logic [N-1:0][LW-1:0]                 alloc_euidx;
  pkg_dtypes::type_iqueue_entry [N-1:0] instr_q;
  logic [N-1:0]                         valid_q;
  logic [N-1:0][LW-1:0]                 euidx_q;
  logic [7:0]                           retry_q;
  logic                                 accepted, ready, capture, load;

  fe_dispatch_euidx_alloc #(.N(N), .LW(LW)) u_alloc (
    .lane_valid  (bus.batch_lane_valid_i),
    .rr_ptr      (rr_ptr),
    .euidx       (alloc_euidx),
    .rr_ptr_next (rr_ptr_next)
  );

  always_comb begin
    accepted = (state_q == HOLD) && !(|bus.eu_is_full_i);
    ready    = !bus.flush_i && ((state_q == IDLE) || accepted);
    capture  = bus.batch_valid_i && ready;
    // An all-invalid batch is consumed but never held.
    load     = capture && (|bus.batch_lane_valid_i);
    state_d  = state_q;
    if (bus.flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (load) state_d = HOLD;
        HOLD:    if (accepted) state_d = load ? HOLD : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rr_ptr  <= '0;
      retry_q <= '0;
      instr_q <= '0;
      valid_q <= '0;
      euidx_q <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        instr_q <= bus.batch_instr_i;
        valid_q <= bus.batch_lane_valid_i;
        euidx_q <= alloc_euidx;
      end
      // capture is never true with flush, so rr_ptr is stable across flushes.
      if (capture) rr_ptr <= rr_ptr_next;
      if ((state_q == HOLD) && !accepted && (retry_q != 8'hFF))
        retry_q <= retry_q + 8'd1;
    end
  end

  // Held registers are only exposed in HOLD so the bus reads as zero in IDLE.
  assign bus.batch_ready_o                  = ready;
  assign bus.dispatched_instr_o             = (state_q == HOLD) ? instr_q : '0;
  assign bus.dispatched_instr_valid_o       = (state_q == HOLD) ? valid_q : '0;
  assign bus.dispatched_instr_alloc_euidx_o = (state_q == HOLD) ? euidx_q : '0;
  assign bus.retry_count_o                  = retry_q;
endmodule
